// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and GF(2^8) round helpers.
// Byte i of a block sits at [127-8i -: 8]; column c is [127-32c -: 32].
package aes_pkg;

    localparam int unsigned NR_128    = 10;
    localparam logic [7:0]  AES_POLY  = 8'h1B;
    localparam int unsigned BLK_W     = 128;
    localparam int unsigned COL_W     = 32;
    localparam int unsigned RK_ADDR_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_SUB,
        ST_MIX,
        ST_DONE
    } aes_state_e;

    // Multiply by x in GF(2^8), reducing by x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    // Row r rotates left by r columns.
    function automatic logic [BLK_W-1:0] shift_rows(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[BLK_W-1 - 8*(4*c + r) -: 8] = s[BLK_W-1 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [COL_W-1:0] mix_column(input logic [COL_W-1:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    function automatic logic [BLK_W-1:0] mix_columns(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[BLK_W-1 - COL_W*c -: COL_W] = mix_column(s[BLK_W-1 - COL_W*c -: COL_W]);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_round_mix.sv
// Round tail after SubBytes: ShiftRows, MixColumns (skipped on the last
// round) and AddRoundKey. Purely combinational.
module aes_round_mix
    import aes_pkg::*;
(
    input  logic [BLK_W-1:0] i_sb_result,
    input  logic [BLK_W-1:0] i_rk_data,
    input  logic             i_last,
    output logic [BLK_W-1:0] o_next_state_c
);

    logic [BLK_W-1:0] w_shifted;
    logic [BLK_W-1:0] w_mixed;

    always_comb begin
        w_shifted      = shift_rows(i_sb_result);
        w_mixed        = mix_columns(w_shifted);
        o_next_state_c = (i_last ? w_shifted : w_mixed) ^ i_rk_data;
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer around an external registered
// SubBytes unit and a 1-cycle round-key memory; one block in flight.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NR         = NR_128,
    parameter int unsigned SB_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BLK_W-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BLK_W-1:0]     out_data,
    output logic                 busy,
    output logic [BLK_W-1:0]     sb_data,
    input  logic [BLK_W-1:0]     sb_result,
    output logic [RK_ADDR_W-1:0] rk_addr,
    input  logic [BLK_W-1:0]     rk_data
);

    localparam int unsigned LAT_W = (SB_LATENCY > 1) ? $clog2(SB_LATENCY) : 1;
    localparam logic [LAT_W-1:0]     LAT_LAST = LAT_W'(SB_LATENCY - 1);
    localparam logic [RK_ADDR_W-1:0] LAST_RND = RK_ADDR_W'(NR);

    aes_state_e             r_fsm;
    logic [BLK_W-1:0]       r_data;
    logic [RK_ADDR_W-1:0]   r_round;
    logic [LAT_W-1:0]       r_lat_cnt;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic                   r_busy;
    logic [RK_ADDR_W-1:0]   r_rk_addr;

    aes_state_e             w_fsm_nxt;
    logic [BLK_W-1:0]       w_data_nxt;
    logic [RK_ADDR_W-1:0]   w_round_nxt;
    logic [LAT_W-1:0]       w_lat_nxt;
    logic                   w_in_ready_nxt;
    logic                   w_out_valid_nxt;
    logic                   w_busy_nxt;
    logic [RK_ADDR_W-1:0]   w_rk_addr_nxt;
    logic                   w_last;
    logic [BLK_W-1:0]       w_round_out;

    assign w_last = (r_round == LAST_RND);

    aes_round_mix u_mix (
        .i_sb_result    (sb_result),
        .i_rk_data      (rk_data),
        .i_last         (w_last),
        .o_next_state_c (w_round_out)
    );

    // State register; reset aborts any block in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fsm       <= ST_IDLE;
            r_data      <= '0;
            r_round     <= '0;
            r_lat_cnt   <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_rk_addr   <= '0;
        end else begin
            r_fsm       <= w_fsm_nxt;
            r_data      <= w_data_nxt;
            r_round     <= w_round_nxt;
            r_lat_cnt   <= w_lat_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_rk_addr   <= w_rk_addr_nxt;
        end
    end

    // Next-state logic; outputs are decoded from next state so they register cleanly.
    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_data_nxt  = r_data;
        w_round_nxt = r_round;
        w_lat_nxt   = r_lat_cnt;

        case (r_fsm)
            ST_IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_data_nxt = in_data;
                    w_fsm_nxt  = ST_INIT;
                end
            end
            ST_INIT: begin
                w_data_nxt  = r_data ^ rk_data;
                w_round_nxt = RK_ADDR_W'(1);
                w_lat_nxt   = '0;
                w_fsm_nxt   = ST_SUB;
            end
            ST_SUB: begin
                w_lat_nxt = r_lat_cnt + 1'b1;
                if (r_lat_cnt == LAT_LAST) begin
                    w_fsm_nxt = ST_MIX;
                end
            end
            ST_MIX: begin
                w_data_nxt = w_round_out;
                if (w_last) begin
                    w_fsm_nxt = ST_DONE;
                end else begin
                    w_round_nxt = r_round + 1'b1;
                    w_lat_nxt   = '0;
                    w_fsm_nxt   = ST_SUB;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_fsm_nxt = ST_IDLE;
                end
            end
            default: begin
                w_fsm_nxt = ST_IDLE;
            end
        endcase

        w_in_ready_nxt  = (w_fsm_nxt == ST_IDLE);
        w_out_valid_nxt = (w_fsm_nxt == ST_DONE);
        w_busy_nxt      = (w_fsm_nxt != ST_IDLE);
        w_rk_addr_nxt   = ((w_fsm_nxt == ST_SUB) || (w_fsm_nxt == ST_MIX)) ? w_round_nxt : '0;
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign rk_addr   = r_rk_addr;
    assign out_data  = r_data;
    assign sb_data   = r_data;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: S-box/key-memory models, a reference AES-128
// encryptor feeding a scoreboard, and one task per scenario.
module tb_aes_round_ctrl;

    logic         clk;
    logic         rst;

    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] in_data, out_data, sb_data, sb_result, rk_data;
    logic [3:0]   rk_addr;

    logic         in_valid2, in_ready2, out_valid2, out_ready2, busy2;
    logic [127:0] in_data2, out_data2, sb_data2, sb_result2, sb_mid2, rk_data2;
    logic [3:0]   rk_addr2;

    logic [7:0]   sbox [256];
    logic [127:0] rkeys [11];
    logic [127:0] exp_q[$];
    logic [127:0] exp_q2[$];

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes_round_ctrl #(.NR(10), .SB_LATENCY(1)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .sb_data(sb_data), .sb_result(sb_result),
        .rk_addr(rk_addr), .rk_data(rk_data)
    );

    aes_round_ctrl #(.NR(10), .SB_LATENCY(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .busy(busy2), .sb_data(sb_data2), .sb_result(sb_result2),
        .rk_addr(rk_addr2), .rk_data(rk_data2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- models ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? (8'({x[6:0], 1'b0}) ^ 8'h1b) : 8'({x[6:0], 1'b0});
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [127:0] sub128(input logic [127:0] x);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = sbox[x[127 - 8*i -: 8]];
        return o;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox[a] = s;
        end
    endtask

    task automatic set_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rkeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ rkeys[0][127 - 8*i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[4*c + r] = t[4*((c + r) % 4) + r];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rkeys[rnd][127 - 8*i -: 8];
        end
        for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
        return o;
    endfunction

    // SubBytes units (1- and 2-deep) and 1-cycle key memories.
    always @(posedge clk) begin
        sb_result  <= sub128(sb_data);
        sb_mid2    <= sub128(sb_data2);
        sb_result2 <= sb_mid2;
        rk_data    <= (rk_addr  <= 4'd10) ? rkeys[rk_addr]  : '0;
        rk_data2   <= (rk_addr2 <= 4'd10) ? rkeys[rk_addr2] : '0;
    end

    // Scoreboard: pop on each output handshake.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: out_data=%h with no block pending", out_data);
            end else if (out_data !== exp_q[0]) begin
                n_fail++;
                $display("FAIL sb_data: got %h expected %h", out_data, exp_q[0]);
                void'(exp_q.pop_front());
            end else begin
                void'(exp_q.pop_front());
            end
        end
        if (rst && out_valid2 && out_ready2) begin
            n_checks++;
            if (exp_q2.size() == 0) begin
                n_fail++;
                $display("FAIL sb2_unexpected: out_data=%h with no block pending", out_data2);
            end else if (out_data2 !== exp_q2[0]) begin
                n_fail++;
                $display("FAIL sb2_data: got %h expected %h", out_data2, exp_q2[0]);
                void'(exp_q2.pop_front());
            end else begin
                void'(exp_q2.pop_front());
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit sel, input logic [127:0] pt, input logic [127:0] exp_ct,
                        input bit push);
        bit ok, rdy;
        int n;
        ok = 1'b0; n = 0;
        if (sel) begin in_valid2 = 1'b1; in_data2 = pt; end
        else     begin in_valid  = 1'b1; in_data  = pt; end
        while (!ok && n < 200) begin
            @(negedge clk);
            rdy = sel ? in_ready2 : in_ready;
            @(posedge clk);
            #1;
            n++;
            if (rdy) ok = 1'b1;
        end
        if (sel) in_valid2 = 1'b0; else in_valid = 1'b0;
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: in_ready=0 for %0d cycles, required 1", n);
        end else if (push) begin
            if (sel) exp_q2.push_back(exp_ct); else exp_q.push_back(exp_ct);
        end
    endtask

    // Returns number of edges from the accept edge until out_valid is seen.
    task automatic wait_out(input bit sel, output int lat);
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if ((sel ? out_valid2 : out_valid) === 1'b1) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) begin
            n_checks++; n_fail++;
            $display("FAIL wait_out_timeout: out_valid=0 after 200 cycles, required 1");
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; in_data2 = '0;
        repeat (3) tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy); end
        n_checks++; if (rk_addr !== 4'd0) begin n_fail++; $display("FAIL rst_rk_addr: got %0d required 0", rk_addr); end
        n_checks++; if (sb_data !== 128'h0) begin n_fail++; $display("FAIL rst_state: got %h required 0", sb_data); end
        rst = 1'b1;
        repeat (2) tick();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_busy: got %b required 0", busy); end
        n_checks++; if (in_ready2 !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready2: got %b required 1", in_ready2); end
    endtask

    task automatic test_fips_c1();
        int lat;
        set_key(KEY_C1);
        out_ready = 1'b1;
        send(1'b0, PT_C1, CT_C1, 1'b1);
        wait_out(1'b0, lat);
        n_checks++; if (lat != 21) begin n_fail++; $display("FAIL c1_latency: got %0d edges required 21", lat); end
        n_checks++; if (out_data !== CT_C1) begin n_fail++; $display("FAIL c1_out_data: got %h required %h", out_data, CT_C1); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL c1_pulse: out_valid=%b required 0", out_valid); end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [127:0] held;
        out_ready = 1'b0;
        send(1'b0, PT_C1, CT_C1, 1'b1);
        wait_out(1'b0, lat);
        held = out_data;
        for (int i = 0; i < 7; i++) begin
            tick();
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b required 1", i, out_valid); end
            n_checks++; if (out_data !== held) begin n_fail++; $display("FAIL bp_stable[%0d]: got %h required %h", i, out_data, held); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b required 0", i, in_ready); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy[%0d]: got %b required 1", i, busy); end
        end
        out_ready = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b required 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        int lat;
        int bad_idx;
        logic [127:0] pt_b;
        logic [3:0]   exp_rk [23];
        logic [3:0]   got_rk [23];
        pt_b = {$urandom, $urandom, $urandom, $urandom};
        exp_rk[0] = 4'd0; exp_rk[1] = 4'd0; exp_rk[22] = 4'd0;
        for (int r = 1; r <= 10; r++) begin
            exp_rk[2*r]   = 4'(r);
            exp_rk[2*r+1] = 4'(r);
        end
        out_ready = 1'b0;
        send(1'b0, PT_C1, CT_C1, 1'b1);
        in_valid = 1'b1; in_data = pt_b;
        wait_out(1'b0, lat);
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_done_in_ready[%0d]: got %b required 0", i, in_ready); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_done_busy[%0d]: got %b required 1", i, busy); end
        end
        out_ready = 1'b1;
        tick();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_in_ready: got %b required 1", in_ready); end
        got_rk[0] = rk_addr;
        for (int i = 1; i < 23; i++) begin
            tick();
            if (i == 1) begin
                in_valid = 1'b0;
                exp_q.push_back(ref_encrypt(pt_b));
            end
            got_rk[i] = rk_addr;
        end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second_valid: got %b required 1 at edge 21", out_valid); end
        bad_idx = -1;
        for (int i = 0; i < 23; i++) if (bad_idx < 0 && got_rk[i] !== exp_rk[i]) bad_idx = i;
        n_checks++;
        if (bad_idx >= 0) begin
            n_fail++;
            $display("FAIL b2b_rk_addr_seq: cycle %0d got %0d required %0d", bad_idx, got_rk[bad_idx], exp_rk[bad_idx]);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat;
        out_ready = 1'b1;
        send(1'b0, PT_C1, CT_C1, 1'b0);
        repeat (8) tick();
        rst = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid: got %b required 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b required 0", busy); end
        n_checks++; if (sb_data !== 128'h0) begin n_fail++; $display("FAIL rmid_state: got %h required 0", sb_data); end
        n_checks++; if (rk_addr !== 4'd0) begin n_fail++; $display("FAIL rmid_rk_addr: got %0d required 0", rk_addr); end
        rst = 1'b1;
        tick();
        send(1'b0, PT_C1, CT_C1, 1'b1);
        wait_out(1'b0, lat);
        n_checks++; if (lat != 21) begin n_fail++; $display("FAIL rmid_latency: got %0d required 21", lat); end
        tick();
    endtask

    task automatic test_zero();
        int lat;
        set_key(128'h0);
        out_ready = 1'b1;
        send(1'b0, 128'h0, CT_Z, 1'b1);
        wait_out(1'b0, lat);
        n_checks++; if (out_data !== CT_Z) begin n_fail++; $display("FAIL zero_out_data: got %h required %h", out_data, CT_Z); end
        tick();
    endtask

    task automatic test_random();
        bit hs;
        logic [127:0] pt;
        set_key({$urandom, $urandom, $urandom, $urandom});
        for (int b = 0; b < 4; b++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            out_ready = 1'b0;
            send(1'b0, pt, ref_encrypt(pt), 1'b1);
            hs = 1'b0;
            for (int k = 0; k < 300 && !hs; k++) begin
                out_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                if (out_valid && out_ready) hs = 1'b1;
                tick();
            end
            n_checks++;
            if (!hs) begin n_fail++; $display("FAIL rand_timeout[%0d]: no output handshake within 300 cycles", b); end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_lat2();
        int lat;
        set_key(KEY_C1);
        out_ready2 = 1'b1;
        send(1'b1, PT_C1, CT_C1, 1'b1);
        wait_out(1'b1, lat);
        n_checks++; if (lat != 31) begin n_fail++; $display("FAIL lat2_latency: got %0d edges required 31", lat); end
        n_checks++; if (out_data2 !== CT_C1) begin n_fail++; $display("FAIL lat2_out_data: got %h required %h", out_data2, CT_C1); end
        tick();
        n_checks++; if (out_valid2 !== 1'b0) begin n_fail++; $display("FAIL lat2_pulse: got %b required 0", out_valid2); end
    endtask

    initial begin
        build_sbox();
        set_key(KEY_C1);
        test_reset();
        test_fips_c1();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_zero();
        test_random();
        test_lat2();
        repeat (2) tick();
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover: %0d blocks pending, required 0", exp_q.size()); end
        n_checks++; if (exp_q2.size() != 0) begin n_fail++; $display("FAIL sb2_leftover: %0d blocks pending, required 0", exp_q2.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
